// File: rtl/reset_pkg.sv
// ============================================================================
// reset_pkg : shared types for the reset sequencer and its status/CSR readers
// Rev 1.0
// ============================================================================
`default_nettype none

package reset_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_GAP  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b01,
    CAUSE_SW  = 2'b10
  } rst_cause_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_down_counter.sv
// ============================================================================
// rst_down_counter : loadable down counter that saturates at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module rst_down_counter #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_value;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : releases N_DOM domain resets in order with programmable gaps
// Rev 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_pkg::*;
#(
  parameter int N_DOM          = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int SW_HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             sw_rst_req,
  output logic [N_DOM-1:0] domain_rst_n,
  output logic             seq_done,
  output logic [1:0]       rst_cause
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, SW_HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LOAD   = CNT_W'(SW_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOM - 1);

  if ((N_DOM < 1) || (HOLD_CYCLES < 1) || (GAP_CYCLES < 1) || (SW_HOLD_CYCLES < 1))
  begin : g_param_check
    $error("reset_sequencer: every parameter must be >= 1");
  end

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] domain_q, domain_d;
  logic             seq_done_q, seq_done_d;
  rst_cause_e       cause_q, cause_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             last_idx;

  assign last_idx = (idx_q == LAST_IDX);

  // Reset value matches the POR hold load so the count starts on the first edge.
  rst_down_counter #(
    .W       (CNT_W),
    .RST_VAL (HOLD_LOAD)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (sync_rst_n),
    .i_load  (cnt_load),
    .i_value (cnt_load_val),
    .i_dec   (cnt_dec),
    .o_zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = (N_DOM == 1) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_zero && last_idx) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (sw_rst_req) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    domain_d     = domain_q;
    seq_done_d   = seq_done_q;
    cause_d      = cause_q;
    idx_d        = idx_q;
    cnt_load     = 1'b0;
    cnt_load_val = GAP_LOAD;
    cnt_dec      = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          domain_d[0] = 1'b1;
          if (N_DOM == 1) begin
            seq_done_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            idx_d    = IDX_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          for (int i = 0; i < N_DOM; i++) begin
            if (idx_q == IDX_W'(i)) begin
              domain_d[i] = 1'b1;
            end
          end
          if (last_idx) begin
            seq_done_d = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            cnt_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (sw_rst_req) begin
          domain_d     = '0;
          seq_done_d   = 1'b0;
          cause_d      = CAUSE_SW;
          idx_d        = '0;
          cnt_load     = 1'b1;
          cnt_load_val = SW_LOAD;
        end
      end
      default: begin
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      idx_q      <= '0;
      domain_q   <= '0;
      seq_done_q <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else begin
      idx_q      <= idx_d;
      domain_q   <= domain_d;
      seq_done_q <= seq_done_d;
      cause_q    <= cause_d;
    end
  end

  assign domain_rst_n = domain_q;
  assign seq_done     = seq_done_q;
  assign rst_cause    = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : directed + randomized bench for reset_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  localparam int N   = 3;
  localparam int H   = 4;
  localparam int G   = 2;
  localparam int SWH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n   = 1'b0;
  logic         sw      = 1'b0;
  logic [N-1:0] dom;
  logic         done;
  logic [1:0]   cause;

  logic         c_rst_n = 1'b0;
  logic         c_sw    = 1'b0;
  logic [0:0]   c_dom;
  logic         c_done;
  logic [1:0]   c_cause;

  int checks = 0;
  int errors = 0;

  // Model: edges elapsed since the current sequence began, and its cause.
  int m_t   = 0;
  bit m_por = 1'b1;

  reset_sequencer #(
    .N_DOM(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .SW_HOLD_CYCLES(SWH)
  ) dut (
    .clk(clk), .sync_rst_n(rst_n), .sw_rst_req(sw),
    .domain_rst_n(dom), .seq_done(done), .rst_cause(cause)
  );

  reset_sequencer #(
    .N_DOM(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .SW_HOLD_CYCLES(1)
  ) dut_c (
    .clk(clk), .sync_rst_n(c_rst_n), .sw_rst_req(c_sw),
    .domain_rst_n(c_dom), .seq_done(c_done), .rst_cause(c_cause)
  );

  function automatic int seq_len();
    return (m_por ? H : SWH) + (N - 1) * G;
  endfunction

  task automatic check_main(input string tag);
    logic [N-1:0] e_dom;
    logic         e_done;
    logic [1:0]   e_cause;
    int           h;
    h = m_por ? H : SWH;
    for (int i = 0; i < N; i++) e_dom[i] = (m_t >= h + i * G);
    e_done  = (m_t >= seq_len());
    e_cause = m_por ? 2'b01 : 2'b10;
    checks++;
    assert (dom === e_dom) else begin
      errors++;
      $error("FAIL %s domain_rst_n observed %b expected %b (t=%0d)", tag, dom, e_dom, m_t);
    end
    checks++;
    assert (done === e_done) else begin
      errors++;
      $error("FAIL %s seq_done observed %b expected %b (t=%0d)", tag, done, e_done, m_t);
    end
    checks++;
    assert (cause === e_cause) else begin
      errors++;
      $error("FAIL %s rst_cause observed %b expected %b (t=%0d)", tag, cause, e_cause, m_t);
    end
  endtask

  task automatic step(input logic s, input string tag);
    sw = s;
    @(posedge clk);
    if (rst_n) begin
      if (m_t >= seq_len() && s) begin
        m_t   = 0;
        m_por = 1'b0;
      end else if (m_t < seq_len()) begin
        m_t++;
      end
    end
    #1 check_main(tag);
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    m_t   = 0;
    m_por = 1'b1;
    #1 check_main("async_reset");
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_c(input logic e_dom, input logic e_done, input logic [1:0] e_cause,
                         input string tag);
    checks++;
    assert (c_dom[0] === e_dom) else begin
      errors++;
      $error("FAIL %s corner domain_rst_n observed %b expected %b", tag, c_dom[0], e_dom);
    end
    checks++;
    assert (c_done === e_done) else begin
      errors++;
      $error("FAIL %s corner seq_done observed %b expected %b", tag, c_done, e_done);
    end
    checks++;
    assert (c_cause === e_cause) else begin
      errors++;
      $error("FAIL %s corner rst_cause observed %b expected %b", tag, c_cause, e_cause);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_main("reset_state");

    // POR sequence
    release_reset();
    for (int i = 0; i < 10; i++) step(1'b0, "por");

    // Single-cycle SW request in S_DONE
    step(1'b1, "sw_req");
    for (int i = 0; i < 9; i++) step(1'b0, "sw_seq");

    // SW re-sequence, then async reset while at 011
    step(1'b1, "sw_req2");
    for (int i = 0; i < 5; i++) step(1'b0, "sw_to_011");
    assert_reset();
    step(1'b0, "in_reset");
    step(1'b0, "in_reset");

    // POR again with an ignored SW pulse on edge 5
    release_reset();
    for (int i = 1; i <= 10; i++) step(i == 5, "por_sw_ignored");

    // SW request held high: repeating loop
    for (int i = 0; i < 25; i++) step(1'b1, "sw_held");
    step(1'b0, "sw_drop");

    // Randomized requests with occasional async reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        assert_reset();
        step(1'b0, "rand_in_reset");
        release_reset();
      end else begin
        step($urandom_range(0, 3) == 0, "random");
      end
    end

    // Corner instance: N_DOM=1, HOLD=1, SW_HOLD=1
    @(posedge clk);
    #1 check_c(1'b0, 1'b0, 2'b01, "c_reset");
    @(negedge clk);
    c_rst_n = 1'b1;
    @(posedge clk);
    #1 check_c(1'b1, 1'b1, 2'b01, "c_edge1");
    c_sw = 1'b1;
    @(posedge clk);
    #1 check_c(1'b0, 1'b0, 2'b10, "c_sw_edge");
    c_sw = 1'b0;
    @(posedge clk);
    #1 check_c(1'b1, 1'b1, 2'b10, "c_sw_release");
    @(posedge clk);
    #1 check_c(1'b1, 1'b1, 2'b10, "c_hold_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
